// File: rtl/pif_led_sequencer_if.sv
// Control-path bundle between pifctl and the LED sequencer: write strobe,
// shared read/write address, write data and the registered readback.
interface pif_led_sequencer_if #(
  parameter int ADDR_W = 4
);
  // ctl_wr is a single-cycle strobe with no backpressure: the sequencer accepts
  // every write in the cycle it is presented. ctl_addr is also sampled on every
  // cycle, and rd_data returns that register's value one cycle later.
  logic              ctl_wr;
  logic [ADDR_W-1:0] ctl_addr;
  logic [7:0]        ctl_data;
  logic [7:0]        rd_data;

  modport master (output ctl_wr, output ctl_addr, output ctl_data, input rd_data);
  modport slave  (input ctl_wr, input ctl_addr, input ctl_data, output rd_data);
endinterface

// File: rtl/pif_led_sequencer.sv
// Multi-channel LED sequencer: per-channel off/steady/blink/inverted-blink/breathe with PWM duty.
// Define PIF_LED_BREATHE_EN to build the shared breathe ramp; without it MODE 4 drives 0.
module pif_led_sequencer #(
  parameter int NUM_LEDS    = 2,
  parameter int PRESCALE    = 12000,
  parameter int BLINK_TICKS = 8,
  parameter int PWM_BITS    = 8,
  parameter int ADDR_W      = 4
) (
  input  logic                xclk,
  input  logic                sys_rst,
  pif_led_sequencer_if.slave  ctl,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
  localparam logic [ADDR_W-1:0]   CTRL_ADDR = ADDR_W'(2 * NUM_LEDS);

  // Mode 0 and 5..7 fall through to the "off" default of the channel decode.
  localparam logic [2:0] MODE_ON        = 3'd1;
  localparam logic [2:0] MODE_BLINK     = 3'd2;
  localparam logic [2:0] MODE_BLINK_INV = 3'd3;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [BLK_W-1:0]    blink_q, blink_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [2:0]          mode_q   [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_q   [NUM_LEDS];
  logic [2:0]          mode_eff [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_eff [NUM_LEDS];
  logic [NUM_LEDS-1:0] mode_wr, duty_wr;
  logic [NUM_LEDS-1:0] led_d;
  logic [7:0]          rd_q, rd_d;
  logic                tick_raw, resync;
  logic                phase_eff;
  logic [PWM_BITS-1:0] pwm_eff;

  function automatic logic pwm_out(input logic [PWM_BITS-1:0] d,
                                   input logic [PWM_BITS-1:0] cnt);
    return (d == PWM_MAX) || (cnt < d);
  endfunction

  assign resync   = ctl.ctl_wr && (ctl.ctl_addr == CTRL_ADDR) && ctl.ctl_data[0];
  assign tick_raw = (presc_q == PRE_LAST);
  assign tick     = tick_raw && !resync;
  assign ctl.rd_data = rd_q;

  // Resync zeroes the timebase in the cycle it is written, so the LED value
  // computed on that edge already sees phase 0 and PWM count 0.
  assign phase_eff = resync ? 1'b0 : phase_q;
  assign pwm_eff   = resync ? '0 : pwm_q;

  always_comb begin
    presc_d = tick_raw ? '0 : presc_q + 1'b1;
    blink_d = blink_q;
    phase_d = phase_q;
    pwm_d   = pwm_q + 1'b1;
    if (tick_raw) begin
      if (blink_q == BLK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
    if (resync) begin
      presc_d = '0;
      blink_d = '0;
      phase_d = 1'b0;
      pwm_d   = '0;
    end
  end

`ifdef PIF_LED_BREATHE_EN
  localparam logic [2:0] MODE_BREATHE = 3'd4;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t                dir_q, dir_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d, ramp_eff;

  assign ramp_eff = resync ? '0 : ramp_q;

  // Triangle ramp that bounces off both ends instead of wrapping.
  always_comb begin
    dir_d  = dir_q;
    ramp_d = ramp_q;
    if (tick_raw) begin
      case (dir_q)
        DIR_UP: begin
          if (ramp_q == PWM_MAX) begin
            dir_d  = DIR_DOWN;
            ramp_d = ramp_q - 1'b1;
          end else begin
            ramp_d = ramp_q + 1'b1;
          end
        end
        default: begin
          if (ramp_q == '0) begin
            dir_d  = DIR_UP;
            ramp_d = ramp_q + 1'b1;
          end else begin
            ramp_d = ramp_q - 1'b1;
          end
        end
      endcase
    end
    if (resync) begin
      dir_d  = DIR_UP;
      ramp_d = '0;
    end
  end

  always_ff @(posedge xclk or posedge sys_rst) begin
    if (sys_rst) begin
      dir_q  <= DIR_UP;
      ramp_q <= '0;
    end else begin
      dir_q  <= dir_d;
      ramp_q <= ramp_d;
    end
  end
`endif

  // Writes are forwarded into the LED decode so led follows one cycle after ctl_wr.
  always_comb begin
    for (int k = 0; k < NUM_LEDS; k++) begin
      mode_wr[k]  = ctl.ctl_wr && (ctl.ctl_addr == ADDR_W'(2 * k));
      duty_wr[k]  = ctl.ctl_wr && (ctl.ctl_addr == ADDR_W'(2 * k + 1));
      mode_eff[k] = mode_wr[k] ? ctl.ctl_data[2:0] : mode_q[k];
      duty_eff[k] = duty_wr[k] ? ctl.ctl_data[PWM_BITS-1:0] : duty_q[k];
    end
  end

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      case (mode_eff[k])
        MODE_ON:        led_d[k] = pwm_out(duty_eff[k], pwm_eff);
        MODE_BLINK:     led_d[k] = phase_eff & pwm_out(duty_eff[k], pwm_eff);
        MODE_BLINK_INV: led_d[k] = ~phase_eff & pwm_out(duty_eff[k], pwm_eff);
`ifdef PIF_LED_BREATHE_EN
        MODE_BREATHE:   led_d[k] = pwm_out(ramp_eff, pwm_eff);
`endif
        default:        led_d[k] = 1'b0;
      endcase
    end
  end

  // Readback uses the pre-write register contents.
  always_comb begin
    rd_d = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (ctl.ctl_addr == ADDR_W'(2 * k))     rd_d = {5'b0, mode_q[k]};
      if (ctl.ctl_addr == ADDR_W'(2 * k + 1)) rd_d = 8'(duty_q[k]);
    end
  end

  always_ff @(posedge xclk or posedge sys_rst) begin
    if (sys_rst) begin
      presc_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      pwm_q   <= '0;
      led     <= '0;
      rd_q    <= '0;
      for (int k = 0; k < NUM_LEDS; k++) begin
        mode_q[k] <= '0;
        duty_q[k] <= '1;
      end
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      led     <= led_d;
      rd_q    <= rd_d;
      for (int k = 0; k < NUM_LEDS; k++) begin
        if (mode_wr[k]) mode_q[k] <= ctl.ctl_data[2:0];
        if (duty_wr[k]) duty_q[k] <= ctl.ctl_data[PWM_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pif_led_sequencer.sv
// Bench for pif_led_sequencer: directed test-plan steps plus random register traffic,
// all checked every cycle against a time-since-sync arithmetic model.
module tb_pif_led_sequencer;
  localparam int NL   = 2;
  localparam int PRE  = 4;
  localparam int BT   = 2;
  localparam int PB   = 4;
  localparam int AW   = 4;
  localparam int PMAX = (1 << PB) - 1;

  logic          xclk = 1'b0;
  logic          sys_rst;
  logic          tick;
  logic [NL-1:0] led;

  pif_led_sequencer_if #(.ADDR_W(AW)) ctl ();

  pif_led_sequencer #(
    .NUM_LEDS(NL), .PRESCALE(PRE), .BLINK_TICKS(BT), .PWM_BITS(PB), .ADDR_W(AW)
  ) dut (
    .xclk(xclk), .sys_rst(sys_rst), .ctl(ctl), .tick(tick), .led(led)
  );

  always #5 xclk = ~xclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: everything derives from c, the cycle count since reset release or resync.
  int            c;
  logic [2:0]    m_mode [NL];
  logic [PB-1:0] m_duty [NL];
  logic [NL-1:0] exp_led;
  logic [7:0]    exp_rd;

  function automatic bit pwm_m(input int cnt, input int d);
    return (d == PMAX) || (cnt < d);
  endfunction

  function automatic int ramp_m(input int n);
    int r;
    r = n % (2 * PMAX);
    return (r <= PMAX) ? r : 2 * PMAX - r;
  endfunction

  task automatic model_reset();
    c = 0;
    exp_led = '0;
    exp_rd = '0;
    for (int k = 0; k < NL; k++) begin
      m_mode[k] = '0;
      m_duty[k] = '1;
    end
  endtask

  always @(negedge xclk) begin
    if (sys_rst) begin
      model_reset();
      check("led_in_reset", 8'(led), 8'h00);
    end else begin
      int            a, ce, n, pc;
      bit            rs, ph, w;
      logic [2:0]    em [NL];
      logic [PB-1:0] ed [NL];
      logic [NL-1:0] nl;
      a  = int'(ctl.ctl_addr);
      w  = (ctl.ctl_wr === 1'b1);
      rs = w && (a == 2 * NL) && ctl.ctl_data[0];
      check("tick", 8'(tick), 8'(((c % PRE) == PRE - 1) && !rs));
      check("led", 8'(led), 8'(exp_led));
      check("rd_data", ctl.rd_data, exp_rd);
      exp_rd = 8'h00;
      if (a < 2 * NL) exp_rd = a[0] ? 8'(m_duty[a / 2]) : {5'b0, m_mode[a / 2]};
      em = m_mode;
      ed = m_duty;
      if (w && a < 2 * NL) begin
        if (a[0]) ed[a / 2] = ctl.ctl_data[PB-1:0];
        else      em[a / 2] = ctl.ctl_data[2:0];
      end
      ce = rs ? 0 : c;
      n  = ce / PRE;
      pc = ce % (PMAX + 1);
      ph = ((n / BT) % 2) == 1;
      nl = '0;
      for (int k = 0; k < NL; k++) begin
        case (int'(em[k]))
          1: nl[k] = pwm_m(pc, int'(ed[k]));
          2: nl[k] = ph && pwm_m(pc, int'(ed[k]));
          3: nl[k] = !ph && pwm_m(pc, int'(ed[k]));
`ifdef PIF_LED_BREATHE_EN
          4: nl[k] = pwm_m(pc, ramp_m(n));
`endif
          default: nl[k] = 1'b0;
        endcase
      end
      exp_led = nl;
      m_mode = em;
      m_duty = ed;
      c = rs ? 0 : c + 1;
    end
  end

  task automatic write_reg(input int a, input int d);
    @(posedge xclk); #1;
    ctl.ctl_wr = 1'b1;
    ctl.ctl_addr = AW'(a);
    ctl.ctl_data = 8'(d);
    @(posedge xclk); #1;
    ctl.ctl_wr = 1'b0;
  endtask

  task automatic read_reg(input int a, output logic [7:0] v);
    @(posedge xclk); #1;
    ctl.ctl_addr = AW'(a);
    @(posedge xclk);
    @(negedge xclk);
    v = ctl.rd_data;
  endtask

  task automatic count_led0(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge xclk);
      cnt += int'(led[0]);
    end
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    int cnt;
    ctl.ctl_wr = 1'b0;
    ctl.ctl_addr = AW'(1);
    ctl.ctl_data = 8'h00;
    sys_rst = 1'b1;
    repeat (3) @(posedge xclk);
    #1 sys_rst = 1'b0;

    // Idle: first tick in the 4th cycle after release, then every 4th.
    for (int i = 0; i < 12; i++) begin
      @(negedge xclk);
      check("tick_pattern", 8'(tick), 8'((i % 4) == 3));
    end
    check("rd_duty0_reset", ctl.rd_data, 8'h0F);
    repeat (88) @(negedge xclk);
    check("idle_led", 8'(led), 8'h00);

    // Steady mode with several duties.
    write_reg(0, 1);
    @(negedge xclk);
    check("on_full_duty", 8'(led[0]), 8'h01);
    write_reg(1, 4);
    count_led0(16, cnt);
    check("duty4_count", 8'(cnt), 8'd4);
    write_reg(1, 0);
    count_led0(16, cnt);
    check("duty0_count", 8'(cnt), 8'd0);

    // Alternating blink pair from a resync.
    write_reg(1, 15);
    write_reg(0, 2);
    write_reg(2, 3);
    write_reg(4, 1);
    repeat (5) @(negedge xclk);
    check("blink_phase0", 8'(led), 8'h02);
    repeat (8) @(negedge xclk);
    check("blink_phase1", 8'(led), 8'h01);

    // Resync landing on a tick cycle (c=15) suppresses that tick.
    repeat (2) @(posedge xclk);
    @(posedge xclk); #1;
    ctl.ctl_wr = 1'b1;
    ctl.ctl_addr = AW'(4);
    ctl.ctl_data = 8'h01;
    @(negedge xclk);
    check("resync_tick_suppressed", 8'(tick), 8'h00);
    @(posedge xclk); #1;
    ctl.ctl_wr = 1'b0;
    repeat (3) @(negedge xclk);
    check("no_early_tick", 8'(tick), 8'h00);
    @(negedge xclk);
    check("tick_after_resync", 8'(tick), 8'h01);
    check("phase_after_resync", 8'(led), 8'h02);
    read_reg(0, v);
    check("mode0_kept", v, 8'h02);
    read_reg(1, v);
    check("duty0_kept", v, 8'h0F);
    read_reg(2, v);
    check("mode1_kept", v, 8'h03);

    // Breathe: ramp peak after 15 ticks, back to 0 after 30.
    write_reg(0, 4);
    write_reg(4, 1);
    repeat (62) @(negedge xclk);
`ifdef PIF_LED_BREATHE_EN
    check("breathe_peak", 8'(led[0]), 8'h01);
`else
    check("breathe_off_peak", 8'(led[0]), 8'h00);
`endif
    repeat (60) @(negedge xclk);
    check("breathe_floor", 8'(led[0]), 8'h00);
    read_reg(0, v);
    check("mode4_readback", v, 8'h04);

    // Asynchronous reset mid-blink.
    write_reg(0, 2);
    write_reg(4, 1);
    repeat (5) @(negedge xclk);
    check("pre_reset_led", 8'(led), 8'h02);
    #2 sys_rst = 1'b1;
    #1 check("async_reset_led", 8'(led), 8'h00);
    repeat (2) @(posedge xclk);
    #1 sys_rst = 1'b0;
    read_reg(0, v);
    check("mode_after_reset", v, 8'h00);
    write_reg(0, 2);
    write_reg(2, 3);
    @(negedge xclk);
    check("restart_phase0", 8'(led), 8'h02);

    // Random register traffic, reads, resyncs and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge xclk); #1;
      if ($urandom_range(0, 799) == 0) begin
        ctl.ctl_wr = 1'b0;
        sys_rst = 1'b1;
        @(posedge xclk); #1;
        sys_rst = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        int a;
        a = $urandom_range(0, 15);
        ctl.ctl_wr = 1'b1;
        ctl.ctl_addr = AW'(a);
        if (a == 4) ctl.ctl_data = 8'($urandom_range(0, 3));
        else if (a % 2 == 0 && a < 4) ctl.ctl_data = {5'($urandom), 3'($urandom_range(0, 7))};
        else ctl.ctl_data = 8'($urandom);
      end else begin
        ctl.ctl_wr = 1'b0;
        ctl.ctl_addr = AW'($urandom_range(0, 15));
      end
    end
    @(posedge xclk); #1;
    ctl.ctl_wr = 1'b0;
    repeat (5) @(negedge xclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pif_led_sequencer.md
Name: pif_led_sequencer

Overview:
- Parametrised successor to the two-LED red/green flasher-and-pattern-select logic.
- Drives NUM_LEDS outputs, each with an independently programmable mode (off, steady, blink, inverted blink, breathe) and PWM brightness.
- Configured through a registered single-cycle write strobe and address/data from the I2C/Wishbone control path.
- Sits between pifctl and the LED output buffers.

Parameters:
- NUM_LEDS, 2: number of LED channels, 1..8.
- PRESCALE, 12000: xclk cycles per tick, must be ≥ 2.
- BLINK_TICKS, 8: ticks per blink half-period, must be ≥ 1.
- PWM_BITS, 8: PWM counter, duty and ramp width.
- ADDR_W, 4: control address width; 2^ADDR_W must be > 2*NUM_LEDS.

Ports:
- xclk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- ctl_wr  in  1  single-cycle write strobe.
- ctl_addr  in  ADDR_W  register address, used for both write and read.
- ctl_data  in  8  write data.
- rd_data  out  8  registered readback of the register at ctl_addr.
- tick  out  1  one-cycle pulse each prescaler wrap.
- led  out  NUM_LEDS  registered LED drive, 1 = lit.

Behaviour:
- One clock (xclk). Reset is asynchronous, active-high (sys_rst), and clears all state at once.
- Reset values:
  - led = 0, tick = 0, rd_data = 0.
  - All modes = 0 (OFF); all duties = all-ones.
  - Prescaler = 0, blink counter = 0, phase = 0, ramp = 0, ramp direction = up, PWM counter = 0.
- Register map:
  - Addr 2k: MODE for channel k, data[2:0]. Upper bits are ignored and read back as 0.
  - Addr 2k+1: DUTY for channel k, data[PWM_BITS-1:0].
  - Addr 2*NUM_LEDS: CTRL. Bit 0 = RESYNC, write-only and self-clearing; reads as 0.
  - Higher addresses: writes ignored, reads return 0.
- Register write takes effect on the ctl_wr cycle. The new value is visible in led one cycle later.
- rd_data: registered every cycle from the register at ctl_addr (1-cycle latency). A write and a read to the same address in the same cycle returns the old value.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = 1 for exactly the cycle in which the counter equals PRESCALE-1.
- Blink: on each tick the blink counter increments. On reaching BLINK_TICKS-1, phase toggles and the counter returns to 0.
- Breathe ramp (shared by all channels), updated on tick:
  - Direction up: ramp++; at all-ones, direction turns down and ramp decrements instead.
  - Direction down: ramp--; at 0, direction turns up and ramp increments instead.
  - Never wraps; triangle period = 2*(2^PWM_BITS - 1) ticks.
- PWM:
  - Free-running PWM_BITS counter; increments every xclk and wraps from all-ones to 0.
  - pwm(d) = (pwm_cnt < d), except d = all-ones, which is constant 1.
  - d = 0 is constant 0.
- Per-channel next led value:
  - MODE 0 OFF: 0.
  - MODE 1 ON: pwm(duty).
  - MODE 2 BLINK: phase & pwm(duty).
  - MODE 3 BLINK_INV: ~phase & pwm(duty). Pairing MODE 2 and 3 reproduces the legacy alternating red/green pattern.
  - MODE 4 BREATHE: pwm(ramp); duty is ignored.
  - MODE 5..7: 0.
- RESYNC write: in the same cycle, the prescaler, blink counter, phase, ramp and PWM counter return to their reset values and direction returns to up.
  - Mode and duty registers are unchanged.
  - RESYNC has priority over a coincident tick; no tick pulse is issued that cycle.
- Simultaneous tick and register write: both take effect; they are independent.
- Reset mid-operation: all state returns to reset values immediately; led = 0 asynchronously.

Optional Feature:
- PIF_LED_BREATHE_EN defined:
  - Ramp logic present.
  - MODE 4 behaves as BREATHE.
- PIF_LED_BREATHE_EN undefined:
  - No ramp or direction registers.
  - MODE 4 is treated as reserved and drives 0.
  - MODE register still stores and reads back the value 4.
  - RESYNC behaviour is otherwise unchanged.

Test Plan (bench parameters: PRESCALE=4, BLINK_TICKS=2, PWM_BITS=4, NUM_LEDS=2):
- Reset, then 100 cycles idle -> led=00 throughout; tick pulses every 4th cycle, first at cycle 4 after reset release; rd_data at addr 1 = 0x0F.
- MODE0=1, duty default 0x0F -> led[0] constant 1 from cycle after write. DUTY0=4 -> led[0] high 4 of every 16 cycles. DUTY0=0 -> led[0] constant 0.
- MODE0=2, MODE1=3 -> led toggles 01 <-> 10 every 8 cycles (2 ticks); the two bits are never both 1.
- MODE0=4 -> ramp reaches 15 after 15 ticks, then descends to 0 at 30 ticks; led[0] duty tracks ramp. Repeat with macro undefined -> led[0]=0 and readback of addr 0 = 4.
- Mid-blink write 0x01 to addr 4 -> tick suppressed that cycle; phase=0; next tick exactly 4 cycles later; mode/duty readback unchanged.
- Assert sys_rst mid-blink with led=10 -> led=00 with no clock edge; after release, pattern restarts from phase 0 and modes read back 0.
